ieee_to_flopoco: RTL and testbench
==================================

IEEE_TO_FLOPOCO -- requirements
Module: ieee_to_flopoco

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each exception statistics counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port push_in, input, 1 bit: ieee_float is valid this cycle.
REQ-005 SHALL have port ieee_float, input, 64 bits: IEEE-754 double {sign[63], exp[62:52], frac[51:0]}.
REQ-006 SHALL have port clear_stats, input, 1 bit: zeroes all statistics counters.
REQ-007 SHALL have port push_out, output, 1 bit: flopoco_float is valid this cycle.
REQ-008 SHALL have port flopoco_float, output, 66 bits: FloPoCo (11,52) word {exn[65:64], sign[63], exp[62:52], frac[51:0]}.
REQ-009 SHALL have port nan_count, output, CNT_W bits: number of accepted NaN inputs.
REQ-010 SHALL have port inf_count, output, CNT_W bits: number of accepted infinity inputs.
REQ-011 SHALL have port denorm_count, output, CNT_W bits: number of accepted subnormal inputs flushed to zero.

Function
REQ-012 SHALL use exn encoding 00 zero, 01 normal, 10 infinity, 11 NaN.
REQ-013 SHALL implement a 2-stage pipeline: stage 1 registers the input and its classification; stage 2 registers the packed output; push_out is push_in delayed by exactly 2 cycles.
REQ-014 SHALL sustain one conversion per cycle with no backpressure; back-to-back pushes SHALL produce back-to-back push_out.
REQ-015 SHALL classify an input with exp=0 and frac=0 as zero: exn=00, sign kept, exp=0, frac=0.
REQ-016 SHALL classify an input with exp=0 and frac!=0 as subnormal: flush to zero (exn=00, sign kept, exp=0, frac=0).
REQ-017 SHALL classify an input with exp=2047 and frac=0 as infinity: exn=10, sign kept, exp=0, frac=0.
REQ-018 SHALL classify an input with exp=2047 and frac!=0 as NaN: exn=11, sign kept, exp=0, frac=0.
REQ-019 SHALL convert any other input as normal: exn=01, with sign, exp and frac copied unchanged (same bias, no rounding).
REQ-020 SHALL load pipeline data registers only when the corresponding stage valid bit is 1; flopoco_float SHALL hold its last value while push_out=0.
REQ-021 SHALL increment the matching counter by 1 in the cycle a push_in with a NaN, infinity or subnormal input is accepted into stage 1.
REQ-022 SHALL saturate each counter at 2^CNT_W-1, with no wrap-around.
REQ-023 SHALL give clear_stats priority over a same-cycle increment: the counter becomes 0 and the coincident event is not counted.
REQ-024 SHALL ignore ieee_float contents when push_in=0: no counter change and no valid output.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set push_out=0, flopoco_float=0, all stage valid bits=0, and nan_count=inf_count=denorm_count=0.
REQ-026 SHALL drop data in flight when rst is asserted mid-operation; no push_out SHALL be produced for those data after rst deasserts.
REQ-027 SHALL ignore push_in sampled while rst=1; it is neither counted nor converted.
REQ-028 SHALL accept the first valid push_in on the first cycle after rst deasserts and produce push_out 2 cycles later.

Verification
REQ-029 SHALL cover normal values: push 64'h3FF0000000000000, then 64'hC000000000000000 on the next cycle -> push_out on cycles +2 and +3 with 66'h1_3FF0_0000_0000_0000, then 66'h1_C000_0000_0000_0000.
REQ-030 SHALL cover specials: 64'h8000000000000000 -> 66'h0_8000_0000_0000_0000; 64'h7FF0000000000000 -> 66'h2_0000_0000_0000_0000 with inf_count=1; 64'hFFF8000000000000 -> 66'h3_8000_0000_0000_0000 with nan_count=1.
REQ-031 SHALL cover subnormal flush: 64'h0000000000000001 -> 66'h0_0000_0000_0000_0000 with denorm_count=1; 64'h800FFFFFFFFFFFFF -> 66'h0_8000_0000_0000_0000 with denorm_count=2.
REQ-032 SHALL cover saturation and clear: with CNT_W=2, push 5 NaNs -> nan_count stays 3; clear_stats asserted in the same cycle as a 6th NaN push -> nan_count=0 the next cycle.
REQ-033 SHALL cover reset mid-flight: push 2 values, assert rst for 1 cycle before they emerge -> no push_out, all outputs 0; a push 1 cycle after reset -> push_out 2 cycles later.
REQ-034 SHALL cover gaps: alternating push_in 1/0 for 100 random doubles -> push_out pattern equals push_in delayed by 2, and outputs match a reference model bit-exactly.

Source files
------------

// File: rtl/ieee_to_flopoco.sv
// IEEE-754 double to FloPoCo (11,52) converter, two-stage pipeline.
// Subnormals flush to signed zero; NaN/inf/subnormal events are counted.
module ieee_to_flopoco #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_in,
   input  logic [63:0]      ieee_float,
   input  logic             clear_stats,
   output logic             push_out,
   output logic [65:0]      flopoco_float,
   output logic [CNT_W-1:0] nan_count,
   output logic [CNT_W-1:0] inf_count,
   output logic [CNT_W-1:0] denorm_count
);

   localparam logic [1:0] EXN_ZERO = 2'b00;
   localparam logic [1:0] EXN_NORM = 2'b01;
   localparam logic [1:0] EXN_INF  = 2'b10;
   localparam logic [1:0] EXN_NAN  = 2'b11;

   logic [10:0] in_exp;
   logic [51:0] in_frac;
   logic        exp_zero;
   logic        exp_ones;
   logic        frac_nz;
   logic [1:0]  in_exn;

   assign in_exp   = ieee_float[62:52];
   assign in_frac  = ieee_float[51:0];
   assign exp_zero = (in_exp == 11'd0);
   assign exp_ones = &in_exp;
   assign frac_nz  = |in_frac;

   always_comb begin
      in_exn = EXN_NORM;
      unique case (1'b1)
         exp_zero:             in_exn = EXN_ZERO;
         exp_ones && !frac_nz: in_exn = EXN_INF;
         exp_ones && frac_nz:  in_exn = EXN_NAN;
         default:              in_exn = EXN_NORM;
      endcase
   end

   logic        s1_valid;
   logic [63:0] s1_word;
   logic [1:0]  s1_exn;
   logic [65:0] s1_packed;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
         s1_exn   <= EXN_ZERO;
      end else begin
         s1_valid <= push_in;
         if (push_in) begin
            s1_word <= ieee_float;
            s1_exn  <= in_exn;
         end
      end
   end

   // Only normals carry a payload; every special keeps just its sign.
   assign s1_packed = (s1_exn == EXN_NORM) ?
                      {s1_exn, s1_word} :
                      {s1_exn, s1_word[63], 63'd0};

   always_ff @(posedge clk) begin
      if (rst) begin
         push_out      <= 1'b0;
         flopoco_float <= '0;
      end else begin
         push_out <= s1_valid;
         if (s1_valid) flopoco_float <= s1_packed;
      end
   end

   logic nan_hit;
   logic inf_hit;
   logic den_hit;

   assign nan_hit = push_in && (in_exn == EXN_NAN);
   assign inf_hit = push_in && (in_exn == EXN_INF);
   assign den_hit = push_in && exp_zero && frac_nz;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] c,
      input logic             hit
   );
      if (hit && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         nan_count    <= '0;
         inf_count    <= '0;
         denorm_count <= '0;
      end else begin
         nan_count    <= sat_inc(nan_count, nan_hit);
         inf_count    <= sat_inc(inf_count, inf_hit);
         denorm_count <= sat_inc(denorm_count, den_hit);
      end
   end

endmodule

// File: tb/tb_ieee_to_flopoco.sv
// Directed bench for ieee_to_flopoco with 2-bit counters
// so saturation is reachable in a few pushes.
module tb_ieee_to_flopoco;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             push_in;
   logic [63:0]      ieee_float;
   logic             clear_stats;
   logic             push_out;
   logic [65:0]      flopoco_float;
   logic [CNT_W-1:0] nan_count;
   logic [CNT_W-1:0] inf_count;
   logic [CNT_W-1:0] denorm_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ieee_to_flopoco #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .push_in       (push_in),
      .ieee_float    (ieee_float),
      .clear_stats   (clear_stats),
      .push_out      (push_out),
      .flopoco_float (flopoco_float),
      .nan_count     (nan_count),
      .inf_count     (inf_count),
      .denorm_count  (denorm_count)
   );

   task automatic chk(input string tag, input logic [65:0] got,
                      input logic [65:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d);
      push_in    = 1'b1;
      ieee_float = d;
      tick();
      push_in    = 1'b0;
   endtask

   task automatic idle();
      push_in = 1'b0;
      tick();
   endtask

   function automatic logic [65:0] ref_conv(input logic [63:0] d);
      logic [10:0] e;
      logic [51:0] f;
      e = d[62:52];
      f = d[51:0];
      if (e == 11'h000) return {2'b00, d[63], 63'd0};
      if (e == 11'h7FF && f == 52'd0) return {2'b10, d[63], 63'd0};
      if (e == 11'h7FF) return {2'b11, d[63], 63'd0};
      return {2'b01, d};
   endfunction

   logic        ev1, ev2;
   logic [65:0] ew1, ew2;
   logic [63:0] rd;

   initial begin
      rst         = 1'b1;
      push_in     = 1'b1;
      ieee_float  = 64'h7FF8_0000_0000_0000;
      clear_stats = 1'b0;
      tick();
      tick();
      chk("rst push_out", 66'(push_out), 66'd0);
      chk("rst float", flopoco_float, 66'd0);
      chk("rst nan_cnt", 66'(nan_count), 66'd0);
      chk("rst inf_cnt", 66'(inf_count), 66'd0);
      chk("rst den_cnt", 66'(denorm_count), 66'd0);
      rst     = 1'b0;
      push_in = 1'b0;
      idle();
      chk("idle push_out", 66'(push_out), 66'd0);

      // normals back to back
      push(64'h3FF0_0000_0000_0000);
      chk("norm lat1", 66'(push_out), 66'd0);
      push(64'hC000_0000_0000_0000);
      chk("norm0 valid", 66'(push_out), 66'd1);
      chk("norm0 data", flopoco_float, 66'h1_3FF0_0000_0000_0000);
      idle();
      chk("norm1 valid", 66'(push_out), 66'd1);
      chk("norm1 data", flopoco_float, 66'h1_C000_0000_0000_0000);
      idle();
      chk("norm gap", 66'(push_out), 66'd0);
      chk("norm hold", flopoco_float, 66'h1_C000_0000_0000_0000);

      // specials and subnormals streamed
      push(64'h8000_0000_0000_0000);
      push(64'h7FF0_0000_0000_0000);
      chk("inf_cnt", 66'(inf_count), 66'd1);
      chk("negzero", flopoco_float, 66'h0_8000_0000_0000_0000);
      push(64'hFFF8_0000_0000_0000);
      chk("nan_cnt", 66'(nan_count), 66'd1);
      chk("inf data", flopoco_float, 66'h2_0000_0000_0000_0000);
      push(64'h0000_0000_0000_0001);
      chk("den_cnt 1", 66'(denorm_count), 66'd1);
      chk("nan data", flopoco_float, 66'h3_8000_0000_0000_0000);
      push(64'h800F_FFFF_FFFF_FFFF);
      chk("den_cnt 2", 66'(denorm_count), 66'd2);
      chk("sub0 data", flopoco_float, 66'h0_0000_0000_0000_0000);
      idle();
      chk("sub1 data", flopoco_float, 66'h0_8000_0000_0000_0000);
      chk("sub1 valid", 66'(push_out), 66'd1);
      chk("inf_cnt hold", 66'(inf_count), 66'd1);
      idle();
      chk("spec drain", 66'(push_out), 66'd0);

      // clear then saturate
      clear_stats = 1'b1;
      idle();
      clear_stats = 1'b0;
      chk("clr nan", 66'(nan_count), 66'd0);
      chk("clr inf", 66'(inf_count), 66'd0);
      chk("clr den", 66'(denorm_count), 66'd0);
      for (int i = 1; i <= 5; i++) begin
         push(64'h7FF0_0000_0000_0001);
         chk($sformatf("sat nan %0d", i), 66'(nan_count),
             66'((i > 3) ? 3 : i));
      end
      clear_stats = 1'b1;
      push(64'h7FF0_0000_0000_0001);
      clear_stats = 1'b0;
      chk("clr beats inc", 66'(nan_count), 66'd0);
      idle();
      idle();
      idle();

      // reset while two values are in flight
      push(64'h4000_0000_0000_0000);
      rst        = 1'b1;
      push_in    = 1'b1;
      ieee_float = 64'hFFF0_0000_0000_0001;
      tick();
      rst     = 1'b0;
      push_in = 1'b0;
      chk("mid rst valid", 66'(push_out), 66'd0);
      chk("mid rst float", flopoco_float, 66'd0);
      chk("mid rst nan", 66'(nan_count), 66'd0);
      push(64'h4008_0000_0000_0000);
      chk("post rst no A", 66'(push_out), 66'd0);
      idle();
      chk("post rst valid", 66'(push_out), 66'd1);
      chk("post rst data", flopoco_float, 66'h1_4008_0000_0000_0000);
      idle();
      chk("post rst drain", 66'(push_out), 66'd0);

      // alternating pushes of random doubles
      ev1 = 1'b0;
      ew1 = 66'h1_4008_0000_0000_0000;
      ew2 = ew1;
      for (int i = 0; i < 200; i++) begin
         rd = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: rd[62:52] = 11'h000;
            1: rd[62:52] = 11'h7FF;
            2: begin rd[62:52] = 11'h7FF; rd[51:0] = '0; end
            3: begin rd[62:52] = 11'h000; rd[51:0] = '0; end
            default: ;
         endcase
         ev2 = ev1;
         if (ev1) ew2 = ew1;
         ev1 = (i % 2 == 0);
         if (ev1) ew1 = ref_conv(rd);
         push_in    = ev1;
         ieee_float = rd;
         tick();
         chk("gap valid", 66'(push_out), 66'(ev2));
         chk("gap data", flopoco_float, ew2);
      end
      push_in = 1'b0;

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
